// File: rtl/serializer_byte.sv
// Byte-to-bit serializer: one 8-bit word per 8 dclk cycles, with an idle alignment preamble after reset.
// Optional macro SER_LSB_FIRST_EN selects LSB-first transmission (default is MSB-first).
module serializer_byte #(
    parameter logic [7:0]  IDLE_CHAR   = 8'hBC,
    parameter int unsigned ALIGN_WORDS = 4
) (
    input  logic       dclk,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       load_req,
    output logic       active,
    output logic       data_out
);
    localparam int unsigned WORD_W     = 8;
    localparam int unsigned CNT_W      = 3;
    localparam logic [7:0]  ALIGN_LAST = 8'(ALIGN_WORDS - 1);

    typedef enum logic {
        ST_ALIGN  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (ALIGN_WORDS == 0) ? ST_ACTIVE : ST_ALIGN;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] shreg;
    logic [7:0]        align_cnt;
    logic [WORD_W-1:0] word;
    logic              load_edge;

    assign load_edge = (bit_cnt == 3'd7);

    // Word captured at a load edge; payload is only accepted once aligned.
    always_comb begin
        word = IDLE_CHAR;
        if (state == ST_ACTIVE && valid_in) begin
            word = data_in;
        end
    end

    always_ff @(posedge dclk or negedge reset_L) begin
        if (!reset_L) begin
            bit_cnt   <= 3'd7;
            shreg     <= '0;
            align_cnt <= '0;
            state     <= RESET_STATE;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (load_edge) begin
                shreg <= word;
                if (state == ST_ALIGN) begin
                    align_cnt <= align_cnt + 8'd1;
                    if (align_cnt == ALIGN_LAST) begin
                        state <= ST_ACTIVE;
                    end
                end
            end else begin
`ifdef SER_LSB_FIRST_EN
                shreg <= {1'b0, shreg[WORD_W-1:1]};
`else
                shreg <= {shreg[WORD_W-2:0], 1'b0};
`endif
            end
        end
    end

`ifdef SER_LSB_FIRST_EN
    assign data_out = shreg[0];
`else
    assign data_out = shreg[WORD_W-1];
`endif

    assign load_req = reset_L & load_edge;
    assign active   = (state == ST_ACTIVE);

endmodule
